// File: rtl/fwd_sequencer.sv
// Reads a buffered packet out of packet memory and emits it as an AXI-Stream frame.
// Define FWD_SEQ_STATS_EN to build the frame/byte statistics counters.
module fwd_sequencer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [31:0]           len_to_forwarder,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [63:0]           m_tdata,
    output logic [7:0]            m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [31:0]           pkt_count,
    output logic [31:0]           byte_count
);
    localparam int IW = ADDR_WIDTH - 1;
    localparam int BW = ADDR_WIDTH;
    localparam logic [31:0]   MAX_LEN   = 32'd8 << IW;
    localparam logic [BW-1:0] BEATS_MAX = BW'(1) << IW;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_DRAIN, S_DONE, S_COOL
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beats_q, beats_d, addr_q, addr_d, infl_idx_q;
    logic [2:0]    rem_q, rem_d;
    logic          infl_q;
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, rd_ptr_q;

    logic [63:0]   buf_data [2];
    logic [7:0]    buf_keep [2];
    logic          buf_last [2];

    logic          over_len;
    logic [BW-1:0] beats_in;
    logic          issue, pop, valid, cap_last, head_last;
    logic [7:0]    cap_keep, head_keep;
    logic [63:0]   head_data;

    always_comb begin
        over_len = len_to_forwarder > MAX_LEN;
        beats_in = over_len ? BEATS_MAX
                            : len_to_forwarder[BW+2:3] + BW'(len_to_forwarder[2:0] != 3'd0);
    end

    // Beat returning from memory this cycle, tagged with the index of the read that fetched it.
    always_comb begin
        cap_last = (infl_idx_q == beats_q - BW'(1));
        cap_keep = (cap_last && rem_q != 3'd0) ? ((8'd1 << rem_q) - 8'd1) : 8'hFF;
    end

    // An empty buffer falls through, so the returning beat is presented in the cycle it arrives.
    always_comb begin
        valid = (count_q != 2'd0) || infl_q;
        if (count_q == 2'd0) begin
            head_data = forwarder_rd_data;
            head_keep = cap_keep;
            head_last = cap_last;
        end else begin
            head_data = buf_data[rd_ptr_q];
            head_keep = buf_keep[rd_ptr_q];
            head_last = buf_last[rd_ptr_q];
        end
        pop     = valid && m_tready;
        count_d = count_q + {1'b0, infl_q} - {1'b0, pop};
        issue   = (state_q == S_READ) && ((count_q + {1'b0, infl_q}) < 2'd2);
    end

    assign m_tvalid          = valid;
    assign m_tdata           = valid ? head_data : '0;
    assign m_tkeep           = valid ? head_keep : '0;
    assign m_tlast           = valid && head_last;
    assign forwarder_rd_en   = issue;
    assign forwarder_rd_addr = issue ? {1'b0, addr_q[IW-1:0]} : '0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d        = state_q;
        beats_d        = beats_q;
        rem_d          = rem_q;
        addr_d         = addr_q;
        forwarder_done = 1'b0;
        unique case (state_q)
            S_IDLE: if (ready_for_forwarder) begin
                beats_d = beats_in;
                rem_d   = over_len ? 3'd0 : len_to_forwarder[2:0];
                addr_d  = '0;
                state_d = (len_to_forwarder == 32'd0) ? S_DONE : S_READ;
            end
            S_READ: if (issue) begin
                addr_d = addr_q + BW'(1);
                if (addr_q + BW'(1) == beats_q) state_d = S_DRAIN;
            end
            S_DRAIN: if (count_d == 2'd0) state_d = S_DONE;
            S_DONE: begin
                forwarder_done = 1'b1;
                state_d        = S_COOL;
            end
            S_COOL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            infl_q     <= issue;
            infl_idx_q <= addr_q;
            count_q    <= count_d;
            if (infl_q) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // NOTE: the payload storage has no reset; occupancy is reset and outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (infl_q) begin
            buf_data[wr_ptr_q] <= forwarder_rd_data;
            buf_keep[wr_ptr_q] <= cap_keep;
            buf_last[wr_ptr_q] <= cap_last;
        end
    end

`ifdef FWD_SEQ_STATS_EN
    logic [31:0] pkt_q, bytes_q;
    logic [3:0]  pop_bytes;

    always_comb begin
        pop_bytes = '0;
        for (int i = 0; i < 8; i++) pop_bytes = pop_bytes + {3'b0, m_tkeep[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q   <= '0;
            bytes_q <= '0;
        end else if (pop) begin
            pkt_q   <= pkt_q + {31'b0, m_tlast};
            bytes_q <= bytes_q + {28'b0, pop_bytes};
        end
    end

    assign pkt_count  = pkt_q;
    assign byte_count = bytes_q;
`else
    assign pkt_count  = '0;
    assign byte_count = '0;
`endif

endmodule
